// File: rtl/ldl_round_pkg.sv
// Shared sizing and helper functions for the ldl_round round-robin arbiter.
package ldl_round_pkg;

  localparam int unsigned MAX_BIN_WIDTH = 8;
  localparam int unsigned MAX_REQ_WIDTH = 1 << MAX_BIN_WIDTH;

  typedef logic [MAX_REQ_WIDTH-1:0] req_vec_t;

  // One-hot vector with bit `index` set; callers narrow to their own width.
  function automatic req_vec_t onehot(input int unsigned index);
    req_vec_t v;
    v = '0;
    v[index[MAX_BIN_WIDTH-1:0]] = 1'b1;
    return v;
  endfunction

  // First set bit scanning upward from base+1, wrapping, ending at base itself.
  function automatic int unsigned rotate_find_first(input req_vec_t vec,
                                                    input int unsigned base,
                                                    input int unsigned width);
    int unsigned idx;
    int unsigned res;
    logic        hit;
    res = base & (width - 1);
    hit = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ_WIDTH; i++) begin
      idx = (base + i) & (width - 1);
      if (!hit && i <= width && vec[idx[MAX_BIN_WIDTH-1:0]]) begin
        res = idx;
        hit = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ldl_round_find.sv
// Combinational round-robin search: rotate req past base, priority-encode, un-rotate.
module ldl_round_find #(
  parameter int unsigned BIN_WIDTH = 3
) (
  input  logic [(1 << BIN_WIDTH)-1:0] req,
  input  logic [BIN_WIDTH-1:0]        base,
  output logic [BIN_WIDTH-1:0]        nxt,
  output logic                        found
);

  localparam int unsigned REQ_WIDTH = 1 << BIN_WIDTH;

  logic [BIN_WIDTH-1:0]   shift;
  logic [2*REQ_WIDTH-1:0] doubled;
  logic [REQ_WIDTH-1:0]   rotated;
  logic [BIN_WIDTH-1:0]   enc;
  logic                   hit;

  // Index base+1 lands at bit 0 after the rotation; modulo wrap is free.
  assign shift   = base + BIN_WIDTH'(1);
  assign doubled = {req, req};
  assign rotated = REQ_WIDTH'(doubled >> shift);

  always_comb begin
    enc = '0;
    hit = 1'b0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (!hit && rotated[i]) begin
        enc = BIN_WIDTH'(i);
        hit = 1'b1;
      end
    end
  end

  assign nxt   = enc + shift;
  assign found = |req;

endmodule

// File: rtl/ldl_round.sv
// Registered round-robin arbiter with one-hot and binary grant outputs.
// Define LDL_ROUND_ASSERT_EN to compile simulation-only invariant checks.
module ldl_round
  import ldl_round_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(1 << BIN_WIDTH)-1:0] req,
  output logic                        ack,
  output logic [(1 << BIN_WIDTH)-1:0] hot,
  output logic [BIN_WIDTH-1:0]        bin,
  output logic [BIN_WIDTH-1:0]        pre_bin
);

  localparam int unsigned REQ_WIDTH = 1 << BIN_WIDTH;

  logic [BIN_WIDTH-1:0] nxt;
  logic                 found;

  ldl_round_find #(
    .BIN_WIDTH (BIN_WIDTH)
  ) u_find (
    .req   (req),
    .base  (bin),
    .nxt   (nxt),
    .found (found)
  );

  // Pointer resets to the top index so the first search begins at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack     <= 1'b0;
      hot     <= '0;
      bin     <= '1;
      pre_bin <= '1;
    end else if (found) begin
      ack     <= 1'b1;
      hot     <= REQ_WIDTH'(onehot(32'(nxt)));
      bin     <= nxt;
      pre_bin <= bin;
    end else begin
      ack     <= 1'b0;
      hot     <= '0;
    end
  end

`ifdef LDL_ROUND_ASSERT_EN
  logic [REQ_WIDTH-1:0] req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else     req_q <= req;
  end

  always @(negedge clk) begin
    if (!rst) begin
      assert ($onehot0(hot))
        else $error("%0t ldl_round: hot=%0h not zero/one-hot", $time, hot);
      assert (ack == |hot)
        else $error("%0t ldl_round: ack=%0b hot=%0h", $time, ack, hot);
      if (ack) begin
        assert (hot == REQ_WIDTH'(onehot(32'(bin))))
          else $error("%0t ldl_round: hot=%0h bin=%0d", $time, hot, bin);
        assert (req_q[bin])
          else $error("%0t ldl_round: granted bin=%0d with req=%0h", $time, bin, req_q);
        assert (32'(bin) == rotate_find_first(MAX_REQ_WIDTH'(req_q), 32'(pre_bin), REQ_WIDTH))
          else $error("%0t ldl_round: bin=%0d pre_bin=%0d req=%0h", $time, bin, pre_bin, req_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ldl_round.sv
// Directed bench for ldl_round: reset, rotation, idle, single requester, wrap, mid-stream reset.
module tb_ldl_round;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       ack;
  logic [7:0] hot;
  logic [2:0] bin;
  logic [2:0] pre_bin;

  int tests = 0;
  int fails = 0;

  int unsigned rot_bin [8] = '{0, 2, 5, 7, 0, 2, 5, 7};

  ldl_round #(.BIN_WIDTH(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .hot     (hot),
    .bin     (bin),
    .pre_bin (pre_bin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_all(input string tag, input logic a, input logic [7:0] h,
                         input logic [2:0] b, input logic [2:0] p);
    chk({tag, ".ack"}, 32'(ack), 32'(a));
    chk({tag, ".hot"}, 32'(hot), 32'(h));
    chk({tag, ".bin"}, 32'(bin), 32'(b));
    chk({tag, ".pre_bin"}, 32'(pre_bin), 32'(p));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] prev;
    rst = 1'b1;
    req = 8'h00;

    // Reset held for two edges
    step();
    step();
    chk_all("reset", 1'b0, 8'h00, 3'd7, 3'd7);
    rst = 1'b0;
    step();
    chk_all("post_reset_idle", 1'b0, 8'h00, 3'd7, 3'd7);

    // Rotation over 8'ha5
    req  = 8'ha5;
    prev = 3'd7;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all($sformatf("rot%0d", i), 1'b1, 8'(1 << rot_bin[i]), 3'(rot_bin[i]), prev);
      prev = 3'(rot_bin[i]);
    end

    // Idle holds pointers
    req = 8'h00;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_all($sformatf("idle%0d", i), 1'b0, 8'h00, 3'd7, 3'd5);
    end

    // Single requester re-granted each edge
    req = 8'h10;
    step();
    chk_all("single0", 1'b1, 8'h10, 3'd4, 3'd7);
    step();
    chk_all("single1", 1'b1, 8'h10, 3'd4, 3'd4);
    step();
    chk_all("single2", 1'b1, 8'h10, 3'd4, 3'd4);

    // Move pointer to 6, then wrap between 6 and 0
    req = 8'h40;
    step();
    chk_all("to6", 1'b1, 8'h40, 3'd6, 3'd4);
    req = 8'h41;
    step();
    chk_all("wrap0", 1'b1, 8'h01, 3'd0, 3'd6);
    step();
    chk_all("wrap1", 1'b1, 8'h40, 3'd6, 3'd0);
    step();
    chk_all("wrap2", 1'b1, 8'h01, 3'd0, 3'd6);

    // Mid-stream reset: pointer at 0, stream 8'ha5 gives 2 then 5
    req = 8'ha5;
    step();
    chk_all("mid_a", 1'b1, 8'h04, 3'd2, 3'd0);
    step();
    chk_all("mid_b", 1'b1, 8'h20, 3'd5, 3'd2);
    rst = 1'b1;
    #1;
    chk_all("mid_async_rst", 1'b0, 8'h00, 3'd7, 3'd7);
    step();
    chk_all("mid_rst_edge", 1'b0, 8'h00, 3'd7, 3'd7);
    rst = 1'b0;
    step();
    chk_all("restart0", 1'b1, 8'h01, 3'd0, 3'd7);
    step();
    chk_all("restart1", 1'b1, 8'h04, 3'd2, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
